// File: rtl/input_num.sv
// Numeric input port: parses an ASCII stream into 8-bit values in the CPU-selected radix and queues them for CPU reads.
// Latency: a value is readable the cycle after its terminator is accepted; bus_out is combinational from read_val.
// Backpressure: rx_ready drops while the value FIFO is full and rises the cycle after a pop.
module input_num #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] main_bus,
  input  logic       load_mode,
  input  logic       read_val,
  output logic [7:0] bus_out,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       avail,
  output logic       err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_NEG,
    S_NUM,
    S_SKIP
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  mode;
  logic [7:0]  acc, acc_nxt;
  logic        neg, neg_nxt;
  logic        push, parse_err;
  logic [7:0]  push_dat;

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic        full, pop, empty_read, accept;

  logic        is_term, is_minus, dig_ok, wrap;
  logic [3:0]  dig_val;
  logic [4:0]  radix;
  logic [11:0] mac;

  assign full       = (count == FULL_CNT);
  assign avail      = (count != '0);
  assign rx_ready   = ~full & ~reset;
  assign pop        = read_val & avail;
  assign empty_read = read_val & ~avail;
  // A character arriving alongside load_mode is consumed but thrown away.
  assign accept     = rx_valid & rx_ready & ~load_mode;
  assign bus_out    = pop ? mem[rd_ptr] : 8'h00;

  assign is_term  = (rx_data == 8'h0A) || (rx_data == 8'h20);
  assign is_minus = (rx_data == 8'h2D) && (mode == 8'd1);

  always_comb begin
    dig_ok  = 1'b0;
    dig_val = 4'd0;
    radix   = 5'd10;
    case (mode)
      8'd0, 8'd1: begin
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
          dig_ok  = 1'b1;
          dig_val = 4'(rx_data - 8'h30);
        end
      end
      8'd2: begin
        radix = 5'd16;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
          dig_ok  = 1'b1;
          dig_val = 4'(rx_data - 8'h30);
        end else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
          dig_ok  = 1'b1;
          dig_val = 4'(rx_data - 8'h57);
        end else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
          dig_ok  = 1'b1;
          dig_val = 4'(rx_data - 8'h37);
        end
      end
      8'd3: begin
        radix = 5'd8;
        if (rx_data >= 8'h30 && rx_data <= 8'h37) begin
          dig_ok  = 1'b1;
          dig_val = 4'(rx_data - 8'h30);
        end
      end
      default: ;
    endcase
  end

  // Full-width multiply-add so overflow past 8 bits can be flagged.
  assign mac      = 12'(acc) * 12'(radix) + 12'(dig_val);
  assign wrap     = |mac[11:8];
  assign push_dat = neg ? (8'd0 - acc) : acc;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    neg_nxt   = neg;
    push      = 1'b0;
    parse_err = 1'b0;
    if (accept) begin
      case (state)
        S_IDLE: begin
          if (dig_ok) begin
            acc_nxt   = {4'd0, dig_val};
            state_nxt = S_NUM;
          end else if (is_minus) begin
            neg_nxt   = 1'b1;
            acc_nxt   = 8'd0;
            state_nxt = S_NEG;
          end else if (!is_term) begin
            parse_err = 1'b1;
            state_nxt = S_SKIP;
          end
        end
        S_NEG: begin
          if (dig_ok) begin
            acc_nxt   = {4'd0, dig_val};
            state_nxt = S_NUM;
          end else begin
            parse_err = 1'b1;
            neg_nxt   = 1'b0;
            state_nxt = is_term ? S_IDLE : S_SKIP;
          end
        end
        S_NUM: begin
          if (dig_ok) begin
            acc_nxt   = mac[7:0];
            parse_err = wrap;
          end else if (is_term) begin
            push      = 1'b1;
            neg_nxt   = 1'b0;
            state_nxt = S_IDLE;
          end else begin
            parse_err = 1'b1;
            neg_nxt   = 1'b0;
            state_nxt = S_SKIP;
          end
        end
        S_SKIP: begin
          if (is_term) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      mode  <= 8'd0;
      acc   <= 8'd0;
      neg   <= 1'b0;
      err   <= 1'b0;
    end else if (load_mode) begin
      state <= S_IDLE;
      mode  <= main_bus;
      acc   <= 8'd0;
      neg   <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      neg   <= neg_nxt;
      if (parse_err || empty_read) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: tb/tb_input_num.sv
// Bench for input_num: table of token strings, hand-written corner sequences, and randomized token streams vs a token-level model.
module tb_input_num;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] main_bus;
  logic       load_mode;
  logic       read_val;
  logic [7:0] bus_out;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       avail;
  logic       err;

  int checks = 0;
  int errors = 0;

  input_num #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .main_bus(main_bus), .load_mode(load_mode),
    .read_val(read_val), .bus_out(bus_out), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .avail(avail), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0] mode;
    string      txt;
    int         n;
    logic [7:0] v0;
    logic [7:0] v1;
    logic       e;
  } vec_t;

  vec_t vecs[10];

  int        exp_q[$];
  logic      model_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    reset = 1'b1; load_mode = 1'b0; read_val = 1'b0; rx_valid = 1'b0;
    rx_data = 8'h00; main_bus = 8'h00;
    cyc();
    #1;
    chk("rst_rdy_low", rx_ready, 0);
    chk("rst_bus_out", bus_out, 0);
    reset = 1'b0;
    #1;
    chk("rst_rdy_high", rx_ready, 1);
    chk("rst_avail", avail, 0);
    chk("rst_err", err, 0);
  endtask

  task automatic load(input logic [7:0] m);
    main_bus = m; load_mode = 1'b1;
    cyc();
    load_mode = 1'b0;
  endtask

  task automatic send_char(input logic [7:0] c);
    int n = 0;
    rx_data = c; rx_valid = 1'b1;
    #1;
    while (!rx_ready && n < 50) begin
      cyc();
      n++;
    end
    if (!rx_ready) chk("rx_ready_wait", rx_ready, 1);
    cyc();
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic read_chk(input string name, input logic [7:0] exp);
    read_val = 1'b1;
    #1;
    chk(name, bus_out, exp);
    cyc();
    read_val = 1'b0;
    #1;
  endtask

  function automatic int dval(input logic [7:0] c, input int m);
    if (m <= 1) return (c >= "0" && c <= "9") ? int'(c) - 48 : -1;
    if (m == 2) begin
      if (c >= "0" && c <= "9") return int'(c) - 48;
      if (c >= "a" && c <= "f") return int'(c) - 87;
      if (c >= "A" && c <= "F") return int'(c) - 55;
      return -1;
    end
    if (m == 3) return (c >= "0" && c <= "7") ? int'(c) - 48 : -1;
    return -1;
  endfunction

  // One whitespace-delimited token: push its value if every character is a legal digit.
  task automatic model_tok(input string t, input int m);
    int st = 0;
    int v = 0;
    int d;
    int rdx;
    bit ok = 1;
    bit ng = 0;
    rdx = (m == 2) ? 16 : (m == 3) ? 8 : 10;
    if (t.len() == 0) return;
    if (m == 1 && t[0] == 8'h2D) begin
      ng = 1; st = 1;
    end
    if (st == t.len()) begin
      model_err = 1'b1;
      return;
    end
    for (int j = st; j < t.len(); j++) begin
      d = dval(t[j], m);
      if (d < 0) ok = 0;
      else if (ok) begin
        v = v * rdx + d;
        if (v > 255) model_err = 1'b1;
        v = v % 256;
      end
    end
    if (!ok) begin
      model_err = 1'b1;
      return;
    end
    exp_q.push_back(ng ? (256 - v) % 256 : v);
  endtask

  task automatic model_str(input string s, input int m);
    int st = 0;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0A || s[i] == 8'h20) begin
        if (i > st) model_tok(s.substr(st, i - 1), m);
        st = i + 1;
      end
    end
  endtask

  function automatic logic [7:0] rand_char(input int m);
    string good;
    string bad = "-8g:x";
    good = (m == 2) ? "0123456789abcdefABCDEF" : (m == 3) ? "01234567" : "0123456789";
    if ($urandom_range(0, 7) == 0) return bad[$urandom_range(0, bad.len() - 1)];
    return good[$urandom_range(0, good.len() - 1)];
  endfunction

  initial begin
    vecs[0] = '{8'd0, "123\n",   1, 8'h7B, 8'h00, 1'b0};
    vecs[1] = '{8'd1, "-5 7\n",  2, 8'hFB, 8'h07, 1'b0};
    vecs[2] = '{8'd2, "fF\n",    1, 8'hFF, 8'h00, 1'b0};
    vecs[3] = '{8'd3, "377 8\n", 1, 8'hFF, 8'h00, 1'b1};
    vecs[4] = '{8'd0, "300\n",   1, 8'h2C, 8'h00, 1'b1};
    vecs[5] = '{8'd1, "200\n",   1, 8'hC8, 8'h00, 1'b0};
    vecs[6] = '{8'd1, "-\n",     0, 8'h00, 8'h00, 1'b1};
    vecs[7] = '{8'd7, "5\n",     0, 8'h00, 8'h00, 1'b1};
    vecs[8] = '{8'd2, "-1 a ",   1, 8'h0A, 8'h00, 1'b1};
    vecs[9] = '{8'd0, "  7\n",   1, 8'h07, 8'h00, 1'b0};

    reset_dut();

    for (int i = 0; i < 10; i++) begin
      reset_dut();
      load(vecs[i].mode);
      send_str(vecs[i].txt);
      #1;
      chk($sformatf("vec%0d_avail", i), avail, (vecs[i].n > 0));
      if (vecs[i].n >= 1) read_chk($sformatf("vec%0d_v0", i), vecs[i].v0);
      if (vecs[i].n >= 2) read_chk($sformatf("vec%0d_v1", i), vecs[i].v1);
      chk($sformatf("vec%0d_empty", i), avail, 0);
      chk($sformatf("vec%0d_err", i), err, vecs[i].e);
    end

    // avail rises exactly one cycle after the terminator is accepted
    reset_dut();
    send_str("42");
    rx_data = 8'h0A; rx_valid = 1'b1;
    #1;
    chk("term_avail_before", avail, 0);
    cyc();
    rx_valid = 1'b0;
    #1;
    chk("term_avail_after", avail, 1);
    read_chk("term_val", 8'd42);

    // load_mode clears err but keeps queued values
    reset_dut();
    send_str("300\n");
    #1;
    chk("wrap_err", err, 1);
    load(8'd0);
    #1;
    chk("load_err_clr", err, 0);
    chk("load_keeps_fifo", avail, 1);
    read_chk("load_kept_val", 8'h2C);

    // full FIFO holds off the fifth character until a pop
    reset_dut();
    send_str("1 2 3 4 ");
    #1;
    chk("full_rdy", rx_ready, 0);
    rx_data = "5"; rx_valid = 1'b1;
    cyc(); cyc();
    #1;
    chk("held_rdy", rx_ready, 0);
    read_val = 1'b1;
    #1;
    chk("full_pop1", bus_out, 8'd1);
    cyc();
    read_val = 1'b0;
    #1;
    chk("rdy_after_pop", rx_ready, 1);
    cyc();
    rx_valid = 1'b0;
    send_str(" ");
    read_chk("full_pop2", 8'd2);
    read_chk("full_pop3", 8'd3);
    read_chk("full_pop4", 8'd4);
    read_chk("full_pop5", 8'd5);
    chk("full_drained", avail, 0);
    chk("full_no_err", err, 0);

    // empty read: zero on the bus, sticky error
    reset_dut();
    read_val = 1'b1;
    #1;
    chk("empty_bus", bus_out, 0);
    cyc();
    read_val = 1'b0;
    #1;
    chk("empty_err", err, 1);
    chk("empty_avail", avail, 0);

    // load_mode mid-token discards the partial value
    send_str("12");
    load(8'd0);
    send_str("\n");
    #1;
    chk("midload_avail", avail, 0);
    chk("midload_err", err, 0);

    // reset mid-token loses the token and returns to decimal mode
    load(8'd2);
    send_str("12");
    reset_dut();
    send_str("\n");
    #1;
    chk("midrst_avail", avail, 0);
    send_str("a\n");
    #1;
    chk("midrst_mode0", err, 1);
    chk("midrst_nopush", avail, 0);

    // randomized token streams against the token-level model
    reset_dut();
    for (int it = 0; it < 60; it++) begin
      int m;
      int ntok;
      string s;
      m = ($urandom_range(0, 9) == 0) ? 5 : int'($urandom_range(0, 3));
      load(8'(m));
      exp_q.delete();
      model_err = 1'b0;
      s = "";
      ntok = $urandom_range(1, 4);
      for (int t = 0; t < ntok; t++) begin
        int len;
        len = $urandom_range(1, 3);
        for (int k = 0; k < len; k++) s = {s, string'(rand_char(m))};
        s = {s, ($urandom_range(0, 1) == 0) ? " " : "\n"};
      end
      send_str(s);
      model_str(s, m);
      #1;
      chk($sformatf("rnd%0d_avail", it), avail, (exp_q.size() > 0));
      chk($sformatf("rnd%0d_err", it), err, model_err);
      while (exp_q.size() > 0) read_chk($sformatf("rnd%0d_val", it), 8'(exp_q.pop_front()));
      chk($sformatf("rnd%0d_empty", it), avail, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_num.md
# input_num

Numeric input port for the 8-bit CPU emulator, the receive-side counterpart of the numeric display output. It accepts an ASCII character stream from the host harness and parses it, per a CPU-selected radix/sign mode, into 8-bit values. Parsed values are buffered in a small FIFO; the CPU pops them onto the main bus with a read strobe.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  synchronous, active-high reset; clock is clk
- main_bus  in  8  CPU bus; mode source for load_mode
- load_mode  in  1  latch main_bus into mode register
- read_val  in  1  CPU read strobe; drive head value, pop at posedge
- bus_out  out  8  head FIFO value while read_val high, else 0x00
- rx_data  in  8  ASCII character from host
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  character accepted at posedge when rx_valid & rx_ready
- avail  out  1  FIFO non-empty
- err  out  1  sticky parse/overflow/underflow error

## Operation
- Modes (mode[7:0]): 0 unsigned decimal, 1 signed decimal, 2 hex, 3 octal; any other value: all non-terminator characters are invalid.
- Digit sets: mode 0/1 '0'-'9'; mode 2 '0'-'9','a'-'f','A'-'F'; mode 3 '0'-'7'.
- Terminators: 0x0A ('\n') and 0x20 (' ').
- Parser FSM, state on accepted character:
  - IDLE: digit → acc=digit, NUM; '-' in mode 1 → neg=1, acc=0, NEG; terminator → stay IDLE, no push; other → err=1, SKIP.
  - NEG: digit → acc=digit, NUM; terminator → err=1, IDLE, no push; other → err=1, SKIP.
  - NUM: digit → acc=acc*radix+digit; terminator → push (neg ? -acc : acc) mod 256, clear neg, IDLE; other → err=1, SKIP.
  - SKIP: terminator → IDLE, no push; anything else ignored.
- Arithmetic: acc 8 bits, wraps mod 256; a wrap (true product+digit > 255) sets err but the token is still pushed with the wrapped value. Mode 1 value range is not checked beyond the 8-bit wrap ("200" pushes 0xC8, no err).
- FIFO: DEPTH entries; rx_ready = ~full & ~reset. Push and pop in the same cycle are both performed.
- Read: bus_out = head while read_val & avail; pop at posedge. read_val with FIFO empty: bus_out=0x00, no pop, err=1.
- load_mode: mode<=main_bus, parser→IDLE, acc and neg cleared, err cleared; FIFO contents kept. A character accepted in the same cycle is discarded.
- reset: FIFO empty, mode=0, parser IDLE, acc=0, neg=0, err=0.

## Timing
- Reset values: bus_out=0x00, avail=0, err=0, rx_ready=0 while reset is high, 1 in the first cycle after reset.
- Terminator accepted at edge N → avail=1 and value readable from cycle N+1.
- bus_out is combinational from read_val and the FIFO head (zero-cycle).
- Pop at edge where read_val & avail; next entry visible in the following cycle.
- FIFO full → rx_ready=0 in the same cycle; it rises the cycle after a pop.
- err updates at the edge that accepts the offending character or empty read; it is visible the next cycle.
- Reset asserted mid-token or mid-read: all state cleared at that edge; the partial token is lost.

## Test plan
- Mode 0, send "123\n" → avail rises cycle after '\n'; read_val → bus_out=0x7B, avail=0 after pop, err=0.
- Mode 1 (load_mode with main_bus=1), send "-5 7\n" → two pops give 0xFB then 0x07.
- Mode 2 send "fF\n" → 0xFF; mode 3 send "377 8\n" → 0xFF pushed, '8' sets err, token skipped, one entry only.
- Mode 0 send "300\n" → 0x2C pushed, err=1; then load_mode → err=0, FIFO still holds 0x2C.
- DEPTH=4: send "1 2 3 4 5 " → rx_ready low after 4th push, '5' held; pop once → rx_ready high, '5' pushed; subsequent pops give 2,3,4,5 in order.
- read_val on empty FIFO → bus_out=0x00, err=1; send "12" then load_mode mid-token, then "\n" → no push, avail stays 0.
